// File: rtl/viterbi_test_ctrl.sv
// viterbi_test_ctrl: drives PRBS frames into a Viterbi encoder, with optional
// error injection on the coded pair. It also compares the decoder output
// against a delayed copy of the payload and counts bit errors.
//
// Start handshake: start is a level request with no ready signal. It is
// accepted on any clock edge where the controller is in IDLE, which is
// exactly when busy is low. In every other state start is ignored. Holding
// start high therefore chains frames, with one IDLE cycle between them.
//
// Parameter limits: LAT >= 2 and FLUSH >= 1.
module viterbi_test_ctrl #(
    parameter int LAT   = 12,
    parameter int FLUSH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  frame_len,
    input  logic [4:0]  err_period,
    input  logic        decoder_o,
    output logic        encoder_i,
    output logic        enable_encoder_i,
    output logic [1:0]  err_mask,
    output logic        busy,
    output logic        done,
    output logic [15:0] bit_err_ct,
    output logic [7:0]  inj_ct,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_FLUSH = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // DRAIN keeps the block busy until the last payload bit's compare slot
    // has gone by. That slot falls LAT cycles after the bit was launched.
    localparam int          DRAIN_LEN  = (LAT > FLUSH) ? (LAT - FLUSH) : 1;
    localparam logic [15:0] FLUSH_LAST = 16'(FLUSH - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_LEN - 1);

    state_t         state_q, state_d;
    logic [6:0]     lfsr_q, lfsr_d, lfsr_step;
    logic [7:0]     len_m1_q;     // frame_len - 1; a frame_len of 0 wraps to 255, i.e. 256 bits
    logic [4:0]     period_q;
    logic [7:0]     bit_cnt_q;
    logic [4:0]     inj_cnt_q;
    logic [15:0]    phase_cnt_q;
    logic [LAT-1:0] dl_valid_q;
    logic [LAT-1:0] dl_bit_q;
    logic           accept, in_run, inject, mismatch;
    logic           enc_d, en_d, busy_d, done_d;
    logic [1:0]     mask_d;

    assign accept    = (state_q == S_IDLE) && start;
    assign in_run    = (state_q == S_RUN);
    assign inject    = in_run && (period_q != 5'd0) && (inj_cnt_q == period_q);
    assign lfsr_step = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    assign lfsr_d    = accept ? 7'h7F : (in_run ? lfsr_step : lfsr_q);
    assign mismatch  = dl_valid_q[LAT-1] && (decoder_o != dl_bit_q[LAT-1]);
    assign state_dbg = state_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic: payload bits, then tail bits, then the drain wait, then a done pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (bit_cnt_q == len_m1_q) state_d = S_FLUSH;
            S_FLUSH: if (phase_cnt_q == FLUSH_LAST) state_d = S_DRAIN;
            S_DRAIN: if (phase_cnt_q == DRAIN_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state, so that the registered outputs line up with the state.
    always_comb begin
        enc_d  = (state_d == S_RUN) ? lfsr_d[6] : 1'b0;
        en_d   = (state_d == S_RUN) || (state_d == S_FLUSH);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        mask_d = inject ? 2'b10 : 2'b00;  // describes the bit on the wire this cycle, so it lags that bit by one
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            encoder_i        <= 1'b0;
            enable_encoder_i <= 1'b0;
            err_mask         <= 2'b00;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            encoder_i        <= enc_d;
            enable_encoder_i <= en_d;
            err_mask         <= mask_d;
            busy             <= busy_d;
            done             <= done_d;
        end
    end

    // Frame configuration, PRBS state, and the payload, injection and phase counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q      <= 7'h7F;
            len_m1_q    <= 8'd0;
            period_q    <= 5'd0;
            bit_cnt_q   <= 8'd0;
            inj_cnt_q   <= 5'd0;
            phase_cnt_q <= 16'd0;
        end else begin
            lfsr_q <= lfsr_d;
            if (accept) begin
                len_m1_q  <= frame_len - 8'd1;
                period_q  <= err_period;
                bit_cnt_q <= 8'd0;
                inj_cnt_q <= 5'd0;
            end else if (in_run) begin
                bit_cnt_q <= bit_cnt_q + 8'd1;
                inj_cnt_q <= (inj_cnt_q == period_q) ? 5'd0 : inj_cnt_q + 5'd1;
            end
            phase_cnt_q <= (state_d != state_q) ? 16'd0 : phase_cnt_q + 16'd1;
        end
    end

    // Reference delay line: stage LAT-1 holds the bit that decoder_o is expected to reproduce now.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dl_valid_q <= '0;
            dl_bit_q   <= '0;
        end else begin
            dl_valid_q <= {dl_valid_q[LAT-2:0], in_run};
            dl_bit_q   <= {dl_bit_q[LAT-2:0], encoder_i};
        end
    end

    // Saturating error and injection counters, cleared when a frame is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_err_ct <= 16'd0;
            inj_ct     <= 8'd0;
        end else if (accept) begin
            bit_err_ct <= 16'd0;
            inj_ct     <= 8'd0;
        end else begin
            if (mismatch && (bit_err_ct != 16'hFFFF)) bit_err_ct <= bit_err_ct + 16'd1;
            if (inject && (inj_ct != 8'hFF))          inj_ct     <= inj_ct + 8'd1;
        end
    end

endmodule

// File: tb/tb_viterbi_test_ctrl.sv
// tb_viterbi_test_ctrl: checks frame sequencing, PRBS content, error-mask
// timing, error counting and reset abort. A looped-back decoder model in the
// bench supplies decoder_o, either ideal, inverted or randomly corrupted.
module tb_viterbi_test_ctrl;

    localparam int LAT   = 12;
    localparam int FLUSH = 8;
    localparam int DRAIN = (LAT > FLUSH) ? (LAT - FLUSH) : 1;
    localparam int MAXC  = 16384;
    localparam int NT    = 8;

    typedef struct {
        int flen;
        int per;
        int mode;     // 0 ideal decoder, 1 inverted, 2 random flips
        int exp_err;  // -1: take the value from the model
        int exp_inj;
    } vec_t;

    logic        clk, rst, start, decoder_o;
    logic [7:0]  frame_len;
    logic [4:0]  err_period;
    logic        encoder_i, enable_encoder_i, busy, done;
    logic [1:0]  err_mask;
    logic [15:0] bit_err_ct;
    logic [7:0]  inj_ct;
    logic [2:0]  state_dbg;

    viterbi_test_ctrl #(.LAT(LAT), .FLUSH(FLUSH)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .err_period(err_period), .decoder_o(decoder_o), .encoder_i(encoder_i),
        .enable_encoder_i(enable_encoder_i), .err_mask(err_mask), .busy(busy),
        .done(done), .bit_err_ct(bit_err_ct), .inj_ct(inj_ct), .state_dbg(state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp, n_bad, cyc, dec_mode;
    logic        rec_enc [MAXC];
    logic        rec_en  [MAXC];
    logic [1:0]  rec_mask[MAXC];
    logic        rec_busy[MAXC];
    logic        rec_done[MAXC];
    logic [15:0] rec_err [MAXC];
    logic [7:0]  rec_inj [MAXC];
    bit          flip_at [MAXC];
    logic [5:0]  exp_q[$];
    vec_t        tab[NT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Recorder and decoder model. Cycle k is the interval after the k-th
    // posedge. decoder_o in cycle k echoes encoder_i from cycle k-LAT, with
    // the flip of the current mode applied.
    initial begin
        bit fl;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (cyc >= MAXC) begin
                $display("FAIL cycle_budget: got %0d cycles expected fewer than %0d", cyc, MAXC);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
                $fatal(1, "cycle budget exhausted");
            end
            rec_enc[cyc]  = encoder_i;
            rec_en[cyc]   = enable_encoder_i;
            rec_mask[cyc] = err_mask;
            rec_busy[cyc] = busy;
            rec_done[cyc] = done;
            rec_err[cyc]  = bit_err_ct;
            rec_inj[cyc]  = inj_ct;
            if (dec_mode == 1)      fl = 1'b1;
            else if (dec_mode == 2) fl = ($urandom_range(0, 3) == 0);
            else                    fl = 1'b0;
            flip_at[cyc] = fl;
            decoder_o = ((cyc >= LAT) ? rec_enc[cyc - LAT] : 1'b0) ^ fl;
        end
    end

    // Driver: called at a negedge while the DUT is idle. Returns the index of the cycle in which the accept took effect.
    task automatic start_frame(input int flen, input int per, input int mode, input bit hold, output int a);
        frame_len  = 8'(flen);
        err_period = 5'(per);
        dec_mode   = mode;
        start      = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        a = cyc;
    endtask

    // Reference model for one frame accepted at cycle a. It covers the full run through the first IDLE cycle after done.
    task automatic check_frame(input int a, input int flen, input int per,
                               input int exp_err, input int exp_inj, input string tag);
        int   n, t_done, e_err, e_inj, rel;
        bit   seq[256];
        bit   inj_prev;
        logic [5:0] got, exp;
        n      = (flen == 0) ? 256 : flen;
        t_done = a + n + FLUSH + DRAIN;
        while (cyc < t_done + 1) @(negedge clk);
        // The PRBS output stream obeys o[k+7] = o[k] ^ o[k+1], starting from seven ones.
        for (int i = 0; i < 256; i++) seq[i] = (i < 7) ? 1'b1 : (seq[i-7] ^ seq[i-6]);
        e_inj = 0;
        e_err = 0;
        for (int i = 0; i < n; i++) begin
            if (per != 0 && (i % (per + 1)) == per) e_inj++;
            if (flip_at[a + i + LAT]) e_err++;
        end
        if (exp_err >= 0) e_err = exp_err;
        if (exp_inj >= 0) e_inj = exp_inj;
        for (int t = a; t <= t_done + 1; t++) begin
            rel      = t - a;
            inj_prev = (rel >= 1) && (rel <= n) && (per != 0) && (((rel - 1) % (per + 1)) == per);
            exp_q.push_back({(rel < n) ? seq[rel] : 1'b0,
                             (rel < n + FLUSH) ? 1'b1 : 1'b0,
                             inj_prev ? 2'b10 : 2'b00,
                             (t <= t_done) ? 1'b1 : 1'b0,
                             (t == t_done) ? 1'b1 : 1'b0});
        end
        for (int t = a; t <= t_done + 1; t++) begin
            exp = exp_q.pop_front();
            got = {rec_enc[t], rec_en[t], rec_mask[t], rec_busy[t], rec_done[t]};
            chk($sformatf("%s cyc+%0d {enc,en,mask,busy,done}", tag, t - a), 32'(got), 32'(exp));
        end
        chk({tag, " bit_err_ct"}, 32'(rec_err[t_done]), 32'(e_err));
        chk({tag, " inj_ct"}, 32'(rec_inj[t_done]), 32'(e_inj));
    endtask

    // Aborts a 40-bit frame in RUN cycle 5 and then runs a 4-bit frame in the given decoder mode.
    task automatic reset_abort(input int mode, input int exp_err, input string tag);
        int a, a2, abort_end, pulses;
        start_frame(40, 3, mode, 1'b0, a);
        while (cyc < a + 5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk({tag, " outs in reset"},
            {encoder_i, enable_encoder_i, err_mask, busy, done, bit_err_ct, inj_ct}, 32'd0);
        rst = 1'b1;
        start_frame(4, 0, mode, 1'b0, a2);
        check_frame(a2, 4, 0, exp_err, 0, {tag, " post"});
        abort_end = a + 40 + FLUSH + DRAIN + 2;
        while (cyc < abort_end) @(negedge clk);
        pulses = 0;
        for (int t = a + 6; t <= abort_end; t++) if (rec_done[t] === 1'b1) pulses++;
        chk({tag, " done pulses"}, 32'(pulses), 32'd1);
    endtask

    initial begin
        int         a, a2, fl, pr, md;
        logic [7:0] first8;
        n_cmp = 0; n_bad = 0; dec_mode = 0;
        rst = 1'b0; start = 1'b0; frame_len = 8'd0; err_period = 5'd0; decoder_o = 1'b0;
        tab[0] = '{16, 0, 0, 0, 0};
        tab[1] = '{0, 4, 0, 0, 51};
        tab[2] = '{0, 0, 1, 256, 0};
        tab[3] = '{1, 1, 1, 1, 0};
        tab[4] = '{2, 1, 1, 2, 1};
        tab[5] = '{10, 2, 0, 0, 3};
        tab[6] = '{255, 31, 1, 255, 7};
        tab[7] = '{5, 0, 2, -1, 0};
        first8 = 8'b1111_1110;

        repeat (3) @(negedge clk);
        chk("reset outs", {encoder_i, enable_encoder_i, err_mask, busy, done}, 32'd0);
        chk("reset counters", {bit_err_ct, inj_ct}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int k = 0; k < NT; k++) begin
            start_frame(tab[k].flen, tab[k].per, tab[k].mode, 1'b0, a);
            check_frame(a, tab[k].flen, tab[k].per, tab[k].exp_err, tab[k].exp_inj, $sformatf("vec%0d", k));
        end

        // Start held high: two frames back to back, one IDLE cycle apart, each beginning with the same PRBS prefix.
        start_frame(8, 0, 0, 1'b1, a);
        a2 = a + 8 + FLUSH + DRAIN + 2;
        while (cyc < a2 + 2) @(negedge clk);
        start = 1'b0;
        check_frame(a, 8, 0, 0, 0, "b2b first");
        check_frame(a2, 8, 0, 0, 0, "b2b second");
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("prbs f1 bit%0d", i), 32'(rec_enc[a + i]), 32'(first8[7-i]));
            chk($sformatf("prbs f2 bit%0d", i), 32'(rec_enc[a2 + i]), 32'(first8[7-i]));
        end

        // A start pulse in the middle of RUN must not disturb the frame.
        start_frame(20, 2, 0, 1'b0, a);
        while (cyc < a + 3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_frame(a, 20, 2, 0, 6, "start in run");

        reset_abort(0, 0, "rst ideal");
        reset_abort(1, 4, "rst invert");

        for (int k = 0; k < 12; k++) begin
            fl = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 48));
            pr = int'($urandom_range(0, 31));
            md = int'($urandom_range(0, 2));
            start_frame(fl, pr, md, 1'b0, a);
            check_frame(a, fl, pr, -1, -1, $sformatf("rand%0d len%0d per%0d mode%0d", k, fl, pr, md));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
